// File: rtl/mux_stream_nx1_pkg.sv
// rtl/mux_stream_nx1_pkg.sv - shared mode encodings and counter width for mux_stream_nx1
package mux_stream_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;
  localparam int   CNT_W    = 16;

endpackage

// File: rtl/mux_stream_nx1_if.sv
// rtl/mux_stream_nx1_if.sv - N input channels plus one output stream handshake bundle
interface mux_stream_nx1_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_valid;
  logic                     out_ready;

  // Environment side: producers plus consumer.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  // Selector side.
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_stream_nx1_rr_arbiter.sv
// rtl/mux_stream_nx1_rr_arbiter.sv - round-robin arbiter searching from ptr with wrap
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  input  logic                      en,
  output logic [NUM_CH-1:0]         grant,
  output logic [$clog2(NUM_CH)-1:0] idx
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic found;
  int   cand;

  // Walk ptr, ptr+1, ... modulo NUM_CH and grant the first requester.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_stream_nx1.sv
// rtl/mux_stream_nx1.sv - N:1 stream selector, explicit or round-robin, registered output; MUX_STREAM_CNT_EN adds xfer_cnt
module mux_stream_nx1
  import mux_stream_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  mux_stream_nx1_if.slave           bus,
  input  logic                      mode,
`ifdef MUX_STREAM_CNT_EN
  input  logic [$clog2(NUM_CH)-1:0] sel,
  output logic [CNT_W-1:0]          xfer_cnt
`else
  input  logic [$clog2(NUM_CH)-1:0] sel
`endif
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic              load_en;
  logic              xfer;
  logic [NUM_CH-1:0] sel_grant;
  logic [NUM_CH-1:0] rr_grant;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  rr_idx;
  logic [SEL_W-1:0]  grant_idx;
  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  next_ptr;
  logic [DATA_W-1:0] grant_data;

  // The output register can take a word when empty or being drained this cycle.
  assign load_en = !bus.out_valid || bus.out_ready;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req   (bus.in_valid),
    .ptr   (rr_ptr),
    .en    (mode == MODE_RR),
    .grant (rr_grant),
    .idx   (rr_idx)
  );

  // Explicit select decode; an out-of-range sel matches no channel.
  always_comb begin
    sel_grant = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == SEL_W'(i)) sel_grant[i] = bus.in_valid[i];
    end
  end

  // Pick the grant source by mode and steer the granted channel's word.
  always_comb begin
    grant      = (mode == MODE_RR) ? rr_grant : sel_grant;
    grant_idx  = (mode == MODE_RR) ? rr_idx : sel;
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) grant_data = bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  assign bus.in_ready = (load_en && !rst) ? grant : '0;
  assign xfer         = |bus.in_ready;
  assign next_ptr     = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

  // Output stage and round-robin pointer; the pointer only moves on RR transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      rr_ptr        <= '0;
    end else if (load_en) begin
      bus.out_valid <= xfer;
      if (xfer) begin
        bus.out_data <= grant_data;
        bus.out_ch   <= grant_idx;
        if (mode == MODE_RR) rr_ptr <= next_ptr;
      end
    end
  end

`ifdef MUX_STREAM_CNT_EN
  // Count consumer-side handshakes; wraps naturally at the top value.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_stream_nx1.sv
// tb/tb_mux_stream_nx1.sv - scoreboard bench for mux_stream_nx1
module tb_mux_stream_nx1;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [1:0] sel;
`ifdef MUX_STREAM_CNT_EN
  logic [15:0] xfer_cnt;
  logic [15:0] m_cnt;
`endif

  mux_stream_nx1_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  mux_stream_nx1 #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mode     (mode),
`ifdef MUX_STREAM_CNT_EN
    .sel      (sel),
    .xfer_cnt (xfer_cnt)
`else
    .sel      (sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit         m_valid;
  logic [7:0] m_data;
  logic [1:0] m_ch;
  int         m_ptr;
  logic [9:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d);
    bus.in_data[ch*DATA_W +: DATA_W] = d;
  endtask

  function automatic int model_grant();
    int j;
    if (mode == 1'b0) begin
      if (int'(sel) < NUM_CH && bus.in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      j = (m_ptr + k) % NUM_CH;
      if (bus.in_valid[j]) return j;
    end
    return -1;
  endfunction

  // Inputs are already set at the falling edge; check in_ready, clock once, check outputs.
  task automatic step();
    int               gi;
    logic [NUM_CH-1:0] er;
    bit               load;
    bit               x;
    bit               hs;
    logic [9:0]       w;
    #1;
    load = !m_valid || bus.out_ready;
    gi   = model_grant();
    er   = '0;
    if (load && !rst && gi >= 0) er[gi] = 1'b1;
    check("in_ready", 32'(bus.in_ready), 32'(er));
    x  = |er;
    hs = m_valid && bus.out_ready;
    if (x) sb.push_back({2'(gi), bus.in_data[gi*DATA_W +: DATA_W]});
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = '0;
      m_ptr   = 0;
      sb.delete();
`ifdef MUX_STREAM_CNT_EN
      m_cnt   = '0;
`endif
    end else begin
`ifdef MUX_STREAM_CNT_EN
      if (hs) m_cnt = m_cnt + 16'd1;
`endif
      if (load) begin
        m_valid = x;
        if (x) begin
          w      = sb.pop_front();
          m_ch   = w[9:8];
          m_data = w[7:0];
          if (mode) m_ptr = (gi + 1) % NUM_CH;
        end
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("out_ch", 32'(bus.out_ch), 32'(m_ch));
`ifdef MUX_STREAM_CNT_EN
    check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`endif
    @(negedge clk);
  endtask

  initial begin
    int exp_seq[4];
    m_valid = 1'b0; m_data = '0; m_ch = '0; m_ptr = 0;
`ifdef MUX_STREAM_CNT_EN
    m_cnt = '0;
`endif
    rst  = 1'b1;
    mode = 1'b1;
    sel  = 2'd0;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    set_ch(0, 8'h11); set_ch(1, 8'h22); set_ch(2, 8'hA5); set_ch(3, 8'h44);
    @(negedge clk);

    // Reset held with every channel requesting.
    for (int i = 0; i < 3; i++) step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    step();
    check("first_rr_ch", 32'(bus.out_ch), 32'd0);
    check("first_rr_data", 32'(bus.out_data), 32'h11);

    // Explicit select of ch2, then an idle select.
    mode = 1'b0; sel = 2'd2;
    step();
    check("sel2_data", 32'(bus.out_data), 32'hA5);
    check("sel2_ch", 32'(bus.out_ch), 32'd2);
    sel = 2'd3; bus.in_valid = 4'b0111;
    step();
    check("sel3_idle", 32'(bus.out_valid), 32'd0);

    // Move the pointer to 0 via a ch3 grant, then 8 cycles of full RR.
    mode = 1'b1; bus.in_valid = 4'b1000;
    step();
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_seq", 32'(bus.out_ch), 32'(i % 4));
    end

    // Pointer to 2 via a ch1 grant, then only ch1/ch3 valid.
    bus.in_valid = 4'b0010;
    step();
    bus.in_valid = 4'b1010;
    exp_seq = '{3, 1, 3, 1};
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_sparse", 32'(bus.out_ch), 32'(exp_seq[i]));
    end

    // Backpressure with 8'h3C held, then drain and reload on one edge.
    mode = 1'b0; sel = 2'd0; set_ch(0, 8'h3C); bus.in_valid = 4'b0001;
    step();
    bus.out_ready = 1'b0; bus.in_valid = 4'b1111; set_ch(0, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_hold", 32'(bus.out_data), 32'h3C);
    end
    bus.out_ready = 1'b1; bus.in_valid = 4'b0001;
    step();
    check("bp_reload", 32'(bus.out_data), 32'h5A);

    // Reset while a word is stalled.
    bus.out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("rst_drop", 32'(bus.out_valid), 32'd0);
    rst = 1'b0; bus.out_ready = 1'b1;

    // Random traffic with occasional resets.
    for (int i = 0; i < 150; i++) begin
      bus.in_valid  = 4'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      mode          = 1'($urandom);
      sel           = 2'($urandom);
      rst           = ($urandom_range(0, 29) == 0);
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 8'($urandom));
      step();
    end
    rst = 1'b0;

`ifdef MUX_STREAM_CNT_EN
    rst = 1'b1; step(); rst = 1'b0;
    bus.out_ready = 1'b1; bus.in_valid = 4'b1111; mode = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("cnt_five", 32'(xfer_cnt), 32'd5);
    rst = 1'b1; step(); rst = 1'b0;
    check("cnt_rst", 32'(xfer_cnt), 32'd0);
    step();
    force dut.xfer_cnt = 16'hFFFF;
    #1;
    release dut.xfer_cnt;
    m_cnt = 16'hFFFF;
    step();
    check("cnt_wrap", 32'(xfer_cnt), 32'd0);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_stream_nx1.md
Name: mux_stream_nx1

Overview:
- Parametrised N-channel, W-bit selector with valid/ready handshakes; generalises the gate-level 4:1 mux.
- Each cycle it chooses one input channel, either by explicit select or by round-robin arbitration.
- The chosen word is captured into a registered output stage.
- Sits between multiple producers and a single consumer in datapath/stream designs.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- DATA_W, 8, data width per channel (>=1).
- SEL_W, $clog2(NUM_CH), select/channel-id width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready (combinational).
- mode  input  1  0 = explicit select (MODE_SEL), 1 = round-robin (MODE_RR).
- sel  input  SEL_W  channel index, used in MODE_SEL only.
- out_data  output  DATA_W  registered selected word.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
- Reset asserted mid-transfer drops any held word; no input handshake completes in a cycle where rst=1 (in_ready forced to 0).
- load_en = !out_valid || out_ready. The output stage is a single register with no bubble when the consumer is always ready.
- Grant vector (one-hot or zero):
  - MODE_SEL: grant[sel]=1 if in_valid[sel]. No grant if sel >= NUM_CH.
  - MODE_RR: grant goes to the first i with in_valid[i], searching rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CH.
- in_ready[i] = load_en && grant[i] && !rst. At most one bit is high per cycle.
- Transfer on channel i when in_valid[i] && in_ready[i]. Next cycle: out_data = that channel's data, out_ch = i, out_valid = 1. Latency is exactly 1 cycle.
- If load_en=1 and there is no grant, out_valid goes to 0 next cycle; out_data and out_ch hold their old values.
- If load_en=0 (out_valid && !out_ready), out_data, out_ch and out_valid hold; all in_ready=0.
- Simultaneous output drain and input load: the new word replaces the old one in the same edge.
- rr_ptr:
  - Updates only on a transfer made in MODE_RR, to (granted index + 1) mod NUM_CH.
  - Wrap: a grant to NUM_CH-1 sets the pointer to 0.
  - Held in MODE_SEL.
- Mode switching: a mode change takes effect at the next arbitration (same cycle, combinational). rr_ptr is retained across switches.
- Inputs may change freely while not granted. The block never reorders within a channel.

Optional Feature:
- Macro: MUX_STREAM_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [15:0]: count of output handshakes (out_valid && out_ready).
  - Reset value 0; increments by 1 per handshake; wraps from 16'hFFFF to 0.
  - No effect on the datapath.
- Undefined: the port and counter are absent; the block is otherwise identical.

Decomposition:
- Package mux_stream_pkg:
  - Localparams MODE_SEL=1'b0 and MODE_RR=1'b1.
  - Counter width constant CNT_W=16.
- Sub-module rr_arbiter (NUM_CH parameter):
  - Inputs: req vector, ptr, en.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once; MODE_SEL bypasses it.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0 throughout. First grant after release, in MODE_RR, goes to ch0.
- MODE_SEL, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> out_valid=0 next cycle.
- MODE_RR, all four valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Verifies wrap at NUM_CH-1.
- MODE_RR, only ch1 and ch3 valid, rr_ptr=2 -> grants 3,1,3,1.
- Backpressure: out_ready=0 for 4 cycles with word 8'h3C held -> out_data stays 8'h3C, in_ready=0. Release with ch0 valid -> the drain and the new load occur on the same edge.
- MUX_STREAM_CNT_EN defined: 5 handshakes, then rst -> xfer_cnt reads 5 then 0. Preload 16'hFFFF (force) plus 1 handshake -> 0.
